run_ctrl: RTL
=============

// Module: run_ctrl
// PURPOSE
//  Synthesizable run controller for the CPU top (main). Replaces fixed testbench delays for reset-release and finish.
//  Sequences per-core reset release with optional stagger, counts run cycles, and ends the run on all-cores-halted, cycle timeout or abort.
//  Sits between the bench/board clock/reset and each core's active-high rst input.
// PARAMETERS
//  N_CORES     1     number of core reset channels / halt inputs
//  RST_CYCLES  1     cycles core 0 is held in reset after HOLD entry (>=1)
//  STAGGER     0     extra cycles between successive core releases
//  MAX_CYCLES  256   RUN cycles before timeout (1..2^CNT_W-1)
//  CNT_W       16    width of cycle_cnt
//  AUTO_START  1     1: leave IDLE automatically after reset; 0: wait for start
// PORTS
//  clk        in   1        system clock
//  rst        in   1        asynchronous, active-low reset
//  start      in   1        pulse; IDLE->HOLD (if !AUTO_START), DONE->HOLD
//  abort      in   1        level; forces end of run
//  halt_req   in   N_CORES  per-core halted indication
//  core_rst   out  N_CORES  active-high reset to each core
//  running    out  1        high in RUN
//  done       out  1        high in DONE
//  timeout    out  1        run ended by MAX_CYCLES
//  aborted    out  1        run ended by abort
//  halt_mask  out  N_CORES  sticky record of cores that halted this run
//  cycle_cnt  out  CNT_W    RUN cycles elapsed this run
// BEHAVIOUR
//  All outputs registered. rst low (any time, incl. mid-run): state=IDLE, core_rst=all 1s, running=done=timeout=aborted=0,
//   halt_mask=0, cycle_cnt=0, hold_cnt=0; takes effect immediately, no clock needed.
//  States: IDLE, HOLD, RUN, DONE.
//  IDLE: core_rst all 1s. If AUTO_START or start, go to HOLD on the next edge.
//   With AUTO_START=1, HOLD begins on the first edge after rst rises.
//  HOLD: on entry, hold_cnt=0, cycle_cnt=0, halt_mask=0, and done/timeout/aborted are cleared.
//   hold_cnt increments each cycle.
//   core_rst[i] falls on the edge where hold_cnt == RST_CYCLES-1+i*STAGGER, so core i sees exactly RST_CYCLES+i*STAGGER
//   cycles of reset in HOLD. With STAGGER=0, all cores release together.
//   On the same edge that core N_CORES-1 releases: ->RUN, running=1.
//   halt_req, abort and start are ignored in HOLD.
//  RUN: cycle_cnt increments every cycle.
//   halt_mask <= halt_mask | halt_req. Let all_h = &(halt_mask|halt_req) and tmo = (cycle_cnt==MAX_CYCLES-1).
//   Exit priority on one edge: abort -> DONE, aborted=1; else all_h -> DONE, timeout=0; else tmo -> DONE, timeout=1.
//   On exit: running=0, done=1, cycle_cnt holds its final value (incremented on the exit edge).
//   start is ignored in RUN.
//  DONE: outputs frozen; core_rst stays 0 (cores are not reset again).
//   start -> HOLD, which asserts core_rst=all 1s on that edge and clears status.
//   abort and halt_req are ignored in DONE.
//  cycle_cnt never wraps: MAX_CYCLES <= 2^CNT_W-1 is required, so the counter saturates before overflow.
//  hold_cnt width: $clog2(RST_CYCLES+(N_CORES-1)*STAGGER+1).
//  Default parameters reproduce the legacy bench: one cycle of core reset, then 256 run cycles before timeout.
// TESTING
//  T1 defaults, rst low 2 cycles then high -> core_rst high exactly 1 cycle in HOLD; running=1;
//     after 256 RUN cycles: done=1, timeout=1, cycle_cnt=256.
//  T2 N_CORES=3, RST_CYCLES=4, STAGGER=2 -> core_rst[0/1/2] fall after 4/6/8 HOLD cycles; running rises with core_rst[2].
//  T3 N_CORES=2, halt_req=01 at RUN cycle 10 (1 cycle), then 10 at cycle 20 -> halt_mask=11, done=1 on the cycle-20 edge,
//     timeout=0, cycle_cnt=21.
//  T4 MAX_CYCLES=8, last halt and tmo on the same edge -> done=1, timeout=0; abort on the same edge -> aborted=1, timeout=0.
//  T5 AUTO_START=0: no start -> stays IDLE 50 cycles with core_rst=1; start pulse -> HOLD; from DONE, start -> new run with
//     cleared status and cycle_cnt=0.
//  T6 rst pulled low mid-RUN between clock edges -> all outputs reach reset values before the next edge;
//     restart behaves as in T1.

Source files
------------

// File: rtl/run_ctrl.sv
// Run controller: staggered per-core reset release, run-cycle counting, end-of-run on halt/timeout/abort.
// All outputs registered (1-cycle response to inputs); start/abort/halt_req are only honoured in the states that use them.
module run_ctrl #(
    parameter int N_CORES    = 1,
    parameter int RST_CYCLES = 1,
    parameter int STAGGER    = 0,
    parameter int MAX_CYCLES = 256,
    parameter int CNT_W      = 16,
    parameter int AUTO_START = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [N_CORES-1:0] halt_req,
    output logic [N_CORES-1:0] core_rst,
    output logic               running,
    output logic               done,
    output logic               timeout,
    output logic               aborted,
    output logic [N_CORES-1:0] halt_mask,
    output logic [CNT_W-1:0]   cycle_cnt
);
    localparam int LAST_REL = RST_CYCLES - 1 + (N_CORES - 1) * STAGGER;
    localparam int HW       = $clog2(LAST_REL + 2);
    localparam logic [HW-1:0]    LAST_REL_H = HW'(LAST_REL);
    localparam logic [CNT_W-1:0] TMO_CNT    = CNT_W'(MAX_CYCLES - 1);
    localparam bit               AUTO       = (AUTO_START != 0);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [N_CORES-1:0] core_rst_q, core_rst_d;
    logic               running_q, running_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic               aborted_q, aborted_d;
    logic [N_CORES-1:0] halt_mask_q, halt_mask_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;

    logic [N_CORES-1:0] seen;
    logic               all_h;
    logic               tmo;
    logic               run_end;
    logic               enter_hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            hold_cnt_q  <= '0;
            core_rst_q  <= '1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            aborted_q   <= 1'b0;
            halt_mask_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            core_rst_q  <= core_rst_d;
            running_q   <= running_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            aborted_q   <= aborted_d;
            halt_mask_q <= halt_mask_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    // A core counts as halted if it halts now or already did earlier in this run.
    always_comb begin
        seen    = halt_mask_q | halt_req;
        all_h   = &seen;
        tmo     = (cycle_cnt_q == TMO_CNT);
        run_end = abort || all_h || tmo;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (AUTO || start) state_d = S_HOLD;
            S_HOLD:  if (hold_cnt_q == LAST_REL_H) state_d = S_RUN;
            S_RUN:   if (run_end) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_HOLD;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        enter_hold  = (state_d == S_HOLD) && (state_q != S_HOLD);
        hold_cnt_d  = hold_cnt_q;
        core_rst_d  = core_rst_q;
        running_d   = running_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        aborted_d   = aborted_q;
        halt_mask_d = halt_mask_q;
        cycle_cnt_d = cycle_cnt_q;
        if (enter_hold) begin
            hold_cnt_d  = '0;
            core_rst_d  = '1;
            running_d   = 1'b0;
            done_d      = 1'b0;
            timeout_d   = 1'b0;
            aborted_d   = 1'b0;
            halt_mask_d = '0;
            cycle_cnt_d = '0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                    // Each core passes its release threshold exactly once per HOLD.
                    for (int i = 0; i < N_CORES; i++) begin
                        if (hold_cnt_q == HW'(RST_CYCLES - 1 + i * STAGGER)) core_rst_d[i] = 1'b0;
                    end
                    if (hold_cnt_q == LAST_REL_H) running_d = 1'b1;
                end
                S_RUN: begin
                    cycle_cnt_d = cycle_cnt_q + 1'b1;
                    halt_mask_d = seen;
                    if (run_end) begin
                        running_d = 1'b0;
                        done_d    = 1'b1;
                        aborted_d = abort;
                        timeout_d = !abort && !all_h;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign core_rst  = core_rst_q;
    assign running   = running_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign aborted   = aborted_q;
    assign halt_mask = halt_mask_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule
